trg_pls_spi_master: RTL and testbench



---
 rtl/trg_pls_spi_pkg.sv | 30 +++
 rtl/spi_phase_timer.sv | 24 ++
 rtl/trg_pls_spi_master.sv | 139 +++++++++++++
 tb/tb_trg_pls_spi_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trg_pls_spi_pkg.sv
// Shared definitions for the trigger-pulse SPI command link: FSM states, frame width and frame fields.
package trg_pls_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_t;

    // Frame width agreed with the slave-side trigger-pulse component.
    localparam int TRG_FRAME_BITS = 16;

    localparam int CH_MSB = 15;
    localparam int CH_LSB = 13;
    localparam int PW_MSB = 12;
    localparam int PW_LSB = 0;
    localparam int CH_W   = CH_MSB - CH_LSB + 1;
    localparam int PW_W   = PW_MSB - PW_LSB + 1;

    function automatic logic [TRG_FRAME_BITS-1:0] make_frame(
        input logic [CH_W-1:0] ch,
        input logic [PW_W-1:0] pw
    );
        return {ch, pw};
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter timing one SPI phase; tc is high while the count sits at zero.
module spi_phase_timer (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       tc
);

    logic [7:0] cnt;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign tc = (cnt == 8'd0);

endmodule

// File: rtl/trg_pls_spi_master.sv
// Write-only SPI mode-0 master serialising host words MSB-first into the trigger-pulse slave.
//
// state | meaning
// IDLE  | waiting for a word, tx_ready high
// SETUP | CS asserted, first bit on MOSI, SCLK low
// HI    | SCLK high, slave samples MOSI
// LO    | SCLK low, next bit presented
// HOLD  | CS still asserted after the last falling edge
// GAP   | CS released, minimum inter-frame spacing
module trg_pls_spi_master
    import trg_pls_spi_pkg::*;
#(
    parameter int FRAME_BITS = TRG_FRAME_BITS,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk_50,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  busy,
    output logic                  spi_clk,
    output logic                  spi_cs_n,
    output logic                  spi_mosi
);

    localparam int              BW        = $clog2(FRAME_BITS);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(FRAME_BITS - 1);
    localparam logic [7:0]      HALF_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0]      GAP_LOAD  = 8'(GAP_CYCLES - 1);

    spi_state_t            state;
    spi_state_t            state_nxt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic                  accept;
    logic                  phase_tc;
    logic                  timer_load;
    logic [7:0]            timer_val;
    logic                  frame_active;
    logic                  done_pend;

    assign accept       = tx_valid && tx_ready;
    assign frame_active = (state == ST_SETUP) || (state == ST_HI) ||
                          (state == ST_LO)    || (state == ST_HOLD);

    spi_phase_timer u_phase_timer (
        .clk_50   (clk_50),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (phase_tc)
    );

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        timer_val  = HALF_LOAD;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt  = ST_SETUP;
                    timer_load = 1'b1;
                end
            end
            ST_SETUP: begin
                if (phase_tc) begin
                    state_nxt  = ST_HI;
                    timer_load = 1'b1;
                end
            end
            ST_HI: begin
                if (phase_tc) begin
                    state_nxt  = (bit_cnt == LAST_BIT) ? ST_HOLD : ST_LO;
                    timer_load = 1'b1;
                end
            end
            ST_LO: begin
                if (phase_tc) begin
                    state_nxt  = ST_HI;
                    timer_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (phase_tc) begin
                    state_nxt  = ST_GAP;
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (phase_tc) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs follow the state directly; the SPI pins are decoded from the
    // registered state, so they trail it by one cycle and all move on the same edge.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            done_pend <= 1'b0;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
            busy      <= 1'b0;
            spi_clk   <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_ready <= (state_nxt == ST_IDLE);
            busy     <= (state_nxt != ST_IDLE);

            if (accept) begin
                shift_reg <= tx_data;
                bit_cnt   <= '0;
            end else if ((state == ST_HI) && phase_tc && (bit_cnt != LAST_BIT)) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                bit_cnt   <= bit_cnt + 1'b1;
            end

            done_pend <= (state == ST_HOLD) && phase_tc;
            tx_done   <= done_pend;
            spi_clk   <= (state == ST_HI);
            spi_cs_n  <= !frame_active;
            spi_mosi  <= frame_active ? shift_reg[FRAME_BITS-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_trg_pls_spi_master.sv
// Randomised bench for trg_pls_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) observed by a pin-level frame monitor.
module tb_trg_pls_spi_master;
    import trg_pls_spi_pkg::*;

    localparam int F     = 16;
    localparam int GAP   = 2;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    typedef struct {
        int word;
        int rises;
        int low;
        int fall;
        int rise;
        int first;
    } frame_t;

    logic         clk_50 = 1'b0;
    logic         reset;
    logic [F-1:0] data [2];
    logic [1:0]   valid;
    logic [1:0]   rdy, done, busy, sclk, csn, mosi;

    int n_cmp = 0;
    int n_err = 0;

    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          acc_cnt [2];
    int          acc_e   [2];
    int          done_cnt[2];
    int          done_e  [2];
    int          stray   [2];
    int          rises_c [2];
    int          low_c   [2];
    int          fall_c  [2];
    int          first_c [2];
    logic [31:0] bits_c  [2];
    logic [1:0]  p_sclk, p_csn;
    frame_t      mf;
    frame_t      fq0[$];
    frame_t      fq1[$];

    always #5 clk_50 = ~clk_50;

    trg_pls_spi_master #(.FRAME_BITS(F), .CLK_DIV(DIV_A), .GAP_CYCLES(GAP)) dut_a (
        .clk_50(clk_50), .reset(reset), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(rdy[0]), .tx_done(done[0]), .busy(busy[0]),
        .spi_clk(sclk[0]), .spi_cs_n(csn[0]), .spi_mosi(mosi[0])
    );

    trg_pls_spi_master #(.FRAME_BITS(F), .CLK_DIV(DIV_B), .GAP_CYCLES(GAP)) dut_b (
        .clk_50(clk_50), .reset(reset), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(rdy[1]), .tx_done(done[1]), .busy(busy[1]),
        .spi_clk(sclk[1]), .spi_cs_n(csn[1]), .spi_mosi(mosi[1])
    );

    always @(posedge clk_50) cyc++;

    // Pin-level monitor: rebuilds each frame from the bus as a slave would see it.
    always @(negedge clk_50) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (valid[i] && rdy[i] && !reset) begin
                    acc_cnt[i]++;
                    acc_e[i] = cyc + 1;
                end
                if (!csn[i] && p_csn[i]) fall_c[i] = cyc;
                if (!csn[i]) low_c[i]++;
                if (sclk[i] && !p_sclk[i]) begin
                    if (!csn[i]) begin
                        if (rises_c[i] == 0) first_c[i] = cyc;
                        bits_c[i] = {bits_c[i][30:0], mosi[i]};
                        rises_c[i]++;
                    end else begin
                        stray[i]++;
                    end
                end
                if (csn[i] && !p_csn[i]) begin
                    mf.word  = int'(bits_c[i]);
                    mf.rises = rises_c[i];
                    mf.low   = low_c[i];
                    mf.fall  = fall_c[i];
                    mf.rise  = cyc;
                    mf.first = first_c[i];
                    if (i == 0) fq0.push_back(mf);
                    else        fq1.push_back(mf);
                    bits_c[i]  = '0;
                    rises_c[i] = 0;
                    low_c[i]   = 0;
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    done_e[i] = cyc;
                end
                p_sclk[i] = sclk[i];
                p_csn[i]  = csn[i];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1);
    end

    function automatic int cs_low_len(input int div);
        return div * (2 * F + 1);
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? fq0.size() : fq1.size();
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic pop_frame(input int i, output frame_t f);
        f = '{default: -1};
        if (i == 0 && fq0.size() > 0) f = fq0.pop_front();
        else if (i == 1 && fq1.size() > 0) f = fq1.pop_front();
    endtask

    task automatic send(input int i, input logic [F-1:0] w, output int k);
        int n0 = acc_cnt[i];
        int t = 0;
        data[i]  = w;
        valid[i] = 1'b1;
        do begin
            step();
            t++;
        end while (acc_cnt[i] == n0 && t < 1000);
        valid[i] = 1'b0;
        k = acc_e[i];
        n_cmp++;
        if (acc_cnt[i] == n0) begin
            n_err++;
            $display("FAIL accept_timeout dut%0d: no acceptance in %0d cycles, required one", i, t);
        end
    endtask

    task automatic wait_frames(input int i, input int n);
        int t = 0;
        while (qsize(i) < n && t < 3000) begin
            step();
            t++;
        end
        step(3);
        n_cmp++;
        if (qsize(i) < n) begin
            n_err++;
            $display("FAIL frame_timeout dut%0d: got %0d frames, required %0d", i, qsize(i), n);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        valid    = 2'b00;
        data[0]  = '0;
        data[1]  = '0;
        step(3);
        for (int i = 0; i < 2; i++) begin
            n_cmp += 6;
            if (rdy[i]  !== 1'b1) begin n_err++; $display("FAIL reset_tx_ready dut%0d: got %b required 1", i, rdy[i]); end
            if (done[i] !== 1'b0) begin n_err++; $display("FAIL reset_tx_done dut%0d: got %b required 0", i, done[i]); end
            if (busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d: got %b required 0", i, busy[i]); end
            if (sclk[i] !== 1'b0) begin n_err++; $display("FAIL reset_spi_clk dut%0d: got %b required 0", i, sclk[i]); end
            if (csn[i]  !== 1'b1) begin n_err++; $display("FAIL reset_spi_cs_n dut%0d: got %b required 1", i, csn[i]); end
            if (mosi[i] !== 1'b0) begin n_err++; $display("FAIL reset_spi_mosi dut%0d: got %b required 0", i, mosi[i]); end
            bits_c[i] = '0;
        end
        p_sclk = 2'b00;
        p_csn  = 2'b11;
        mon_en = 1'b1;
        reset  = 1'b0;
        step(2);
    endtask

    task automatic test_single_frame();
        int k;
        int d0 = done_cnt[0];
        frame_t f;
        send(0, 16'hA5C3, k);
        wait_frames(0, 1);
        pop_frame(0, f);
        n_cmp += 8;
        if (f.word  !== 32'h0000A5C3)        begin n_err++; $display("FAIL single_word: got %0h required a5c3", f.word); end
        if (f.rises !== F)                   begin n_err++; $display("FAIL single_rises: got %0d required %0d", f.rises, F); end
        if (f.low   !== cs_low_len(DIV_A))   begin n_err++; $display("FAIL single_cs_low: got %0d required %0d", f.low, cs_low_len(DIV_A)); end
        if (f.fall  !== k + 1)               begin n_err++; $display("FAIL single_cs_fall: got edge %0d required %0d", f.fall, k + 1); end
        if (f.first !== k + 1 + DIV_A)       begin n_err++; $display("FAIL single_first_sclk: got edge %0d required %0d", f.first, k + 1 + DIV_A); end
        if (f.rise  !== k + 1 + cs_low_len(DIV_A)) begin n_err++; $display("FAIL single_cs_rise: got edge %0d required %0d", f.rise, k + 1 + cs_low_len(DIV_A)); end
        if (done_cnt[0] - d0 !== 1)          begin n_err++; $display("FAIL single_done_count: got %0d required 1", done_cnt[0] - d0); end
        if (done_e[0] !== f.rise)            begin n_err++; $display("FAIL single_done_time: got edge %0d required %0d", done_e[0], f.rise); end
    endtask

    task automatic test_back_to_back();
        int n0 = acc_cnt[0];
        int t = 0;
        int k1, k2;
        frame_t f1, f2;
        data[0]  = 16'h0001;
        valid[0] = 1'b1;
        while (acc_cnt[0] == n0 && t < 1000) begin step(); t++; end
        k1 = acc_e[0];
        data[0] = 16'h8000;
        t = 0;
        while (acc_cnt[0] == n0 + 1 && t < 1000) begin step(); t++; end
        k2 = acc_e[0];
        valid[0] = 1'b0;
        wait_frames(0, 2);
        pop_frame(0, f1);
        pop_frame(0, f2);
        n_cmp += 5;
        if (f1.word !== 32'h00000001) begin n_err++; $display("FAIL b2b_word1: got %0h required 0001", f1.word); end
        if (f2.word !== 32'h00008000) begin n_err++; $display("FAIL b2b_word2: got %0h required 8000", f2.word); end
        if (k2 - k1 !== 1 + cs_low_len(DIV_A) + GAP) begin n_err++; $display("FAIL b2b_accept_spacing: got %0d required %0d", k2 - k1, 1 + cs_low_len(DIV_A) + GAP); end
        if (f2.fall - f1.rise !== GAP + 1) begin n_err++; $display("FAIL b2b_cs_gap: got %0d required %0d", f2.fall - f1.rise, GAP + 1); end
        if (f2.low !== cs_low_len(DIV_A)) begin n_err++; $display("FAIL b2b_cs_low2: got %0d required %0d", f2.low, cs_low_len(DIV_A)); end
    endtask

    task automatic test_hold_data();
        int n0 = acc_cnt[0];
        int t = 0;
        int k1, k2;
        frame_t f1, f2;
        data[0]  = 16'hA5C3;
        valid[0] = 1'b1;
        while (acc_cnt[0] == n0 && t < 1000) begin step(); t++; end
        k1 = acc_e[0];
        step(40);
        n_cmp++;
        if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL hold_ready_mid_frame: got %b required 0", rdy[0]); end
        data[0] = 16'h1234;
        t = 0;
        while (acc_cnt[0] == n0 + 1 && t < 1000) begin step(); t++; end
        k2 = acc_e[0];
        valid[0] = 1'b0;
        wait_frames(0, 2);
        pop_frame(0, f1);
        pop_frame(0, f2);
        n_cmp += 3;
        if (f1.word !== 32'h0000A5C3) begin n_err++; $display("FAIL hold_word1: got %0h required a5c3", f1.word); end
        if (f2.word !== 32'h00001234) begin n_err++; $display("FAIL hold_word2: got %0h required 1234", f2.word); end
        if (k2 - k1 !== 1 + cs_low_len(DIV_A) + GAP) begin n_err++; $display("FAIL hold_accept_spacing: got %0d required %0d", k2 - k1, 1 + cs_low_len(DIV_A) + GAP); end
    endtask

    task automatic test_fast_clock();
        int k;
        frame_t f;
        send(1, 16'hFFFF, k);
        wait_frames(1, 1);
        pop_frame(1, f);
        n_cmp += 5;
        if (f.word  !== 32'h0000FFFF)      begin n_err++; $display("FAIL fast_word: got %0h required ffff", f.word); end
        if (f.rises !== F)                 begin n_err++; $display("FAIL fast_rises: got %0d required %0d", f.rises, F); end
        if (f.low   !== cs_low_len(DIV_B)) begin n_err++; $display("FAIL fast_cs_low: got %0d required %0d", f.low, cs_low_len(DIV_B)); end
        if (f.first !== k + 1 + DIV_B)     begin n_err++; $display("FAIL fast_first_sclk: got edge %0d required %0d", f.first, k + 1 + DIV_B); end
        if (f.fall  !== k + 1)             begin n_err++; $display("FAIL fast_cs_fall: got edge %0d required %0d", f.fall, k + 1); end
    endtask

    task automatic test_random();
        logic [F-1:0] exp_q[$];
        int  dut_q[$];
        int  k;
        frame_t f;
        for (int n = 0; n < 10; n++) begin
            int i = int'($urandom_range(0, 1));
            logic [F-1:0] w = make_frame(3'($urandom), 13'($urandom));
            step(int'($urandom_range(1, 6)));
            send(i, w, k);
            wait_frames(i, 1);
            pop_frame(i, f);
            exp_q.push_back(w);
            dut_q.push_back(i);
            n_cmp += 3;
            if (f.word  !== int'(exp_q[$])) begin n_err++; $display("FAIL random_word dut%0d: got %0h required %0h", i, f.word, exp_q[$]); end
            if (f.rises !== F)              begin n_err++; $display("FAIL random_rises dut%0d: got %0d required %0d", i, f.rises, F); end
            if (f.low   !== cs_low_len(div_of(dut_q[$]))) begin n_err++; $display("FAIL random_cs_low dut%0d: got %0d required %0d", i, f.low, cs_low_len(div_of(i))); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int k;
        int t = 0;
        int d0;
        frame_t f;
        send(0, 16'h3C96, k);
        d0 = done_cnt[0];
        while (rises_c[0] < 7 && t < 500) begin step(); t++; end
        reset = 1'b1;
        step();
        n_cmp += 6;
        if (csn[0]  !== 1'b1) begin n_err++; $display("FAIL midreset_cs_n: got %b required 1", csn[0]); end
        if (sclk[0] !== 1'b0) begin n_err++; $display("FAIL midreset_spi_clk: got %b required 0", sclk[0]); end
        if (mosi[0] !== 1'b0) begin n_err++; $display("FAIL midreset_mosi: got %b required 0", mosi[0]); end
        if (rdy[0]  !== 1'b1) begin n_err++; $display("FAIL midreset_tx_ready: got %b required 1", rdy[0]); end
        if (busy[0] !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b required 0", busy[0]); end
        if (done[0] !== 1'b0) begin n_err++; $display("FAIL midreset_tx_done: got %b required 0", done[0]); end
        reset = 1'b0;
        step(cs_low_len(DIV_A) + 10);
        pop_frame(0, f);
        n_cmp += 2;
        if (done_cnt[0] !== d0) begin n_err++; $display("FAIL midreset_no_done: got %0d pulses required 0", done_cnt[0] - d0); end
        if (f.rises !== 7)      begin n_err++; $display("FAIL midreset_truncated_rises: got %0d required 7", f.rises); end
        send(0, 16'h5A5A, k);
        wait_frames(0, 1);
        pop_frame(0, f);
        n_cmp += 3;
        if (f.word  !== 32'h00005A5A)      begin n_err++; $display("FAIL midreset_next_word: got %0h required 5a5a", f.word); end
        if (f.rises !== F)                 begin n_err++; $display("FAIL midreset_next_rises: got %0d required %0d", f.rises, F); end
        if (f.low   !== cs_low_len(DIV_A)) begin n_err++; $display("FAIL midreset_next_cs_low: got %0d required %0d", f.low, cs_low_len(DIV_A)); end
    endtask

    task automatic test_reset_with_valid();
        logic [1:0] low_seen = 2'b00;
        int a0 = acc_cnt[0];
        int a1 = acc_cnt[1];
        data[0] = F'($urandom);
        data[1] = F'($urandom);
        valid   = 2'b11;
        reset   = 1'b1;
        step();
        valid = 2'b00;
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            low_seen = low_seen | ~csn;
            step();
        end
        n_cmp += 3;
        if (low_seen !== 2'b00) begin n_err++; $display("FAIL rstvalid_cs_stays_high: got low mask %b required 00", low_seen); end
        if (qsize(0) + qsize(1) !== 0) begin n_err++; $display("FAIL rstvalid_no_frame: got %0d frames required 0", qsize(0) + qsize(1)); end
        if ((acc_cnt[0] - a0) + (acc_cnt[1] - a1) !== 0) begin n_err++; $display("FAIL rstvalid_no_accept: got %0d required 0", (acc_cnt[0] - a0) + (acc_cnt[1] - a1)); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold_data();
        test_fast_clock();
        test_random();
        test_reset_mid_frame();
        test_reset_with_valid();
        n_cmp += 2;
        if (stray[0] + stray[1] !== 0) begin n_err++; $display("FAIL sclk_outside_cs: got %0d rises required 0", stray[0] + stray[1]); end
        if (qsize(0) + qsize(1) !== 0) begin n_err++; $display("FAIL unexpected_frames: got %0d required 0", qsize(0) + qsize(1)); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
